// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: CPU request/response handshake, DataMemory
// port and memory-mapped IO port. The LSU takes the slave side; the
// surrounding pipeline, DataMemory and IO target together take the master side.
interface load_store_unit_if;
    // CPU request / response
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    // DataMemory port
    logic [31:0] mem_access_addr;
    logic [31:0] mem_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [2:0]  mem_data_size;
    logic [31:0] mem_out;
    // Memory-mapped IO port
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_we;
    logic        io_re;
    logic [2:0]  io_size;
    logic        io_ready;
    logic [31:0] io_rdata;

    modport master (
        output req_valid, req_addr, req_wdata, req_write, req_size,
        output mem_out, io_ready, io_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_access_addr, mem_in, mem_write_en, mem_read_en, mem_data_size,
        input  io_addr, io_wdata, io_we, io_re, io_size
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_write, req_size,
        input  mem_out, io_ready, io_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_access_addr, mem_in, mem_write_en, mem_read_en, mem_data_size,
        output io_addr, io_wdata, io_we, io_re, io_size
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, routes it to DataMemory or
// the memory-mapped IO port by one address bit, and returns exactly one
// single-cycle response per accepted request.
module load_store_unit #(
    parameter int IO_ADDR_BIT = 31,
    parameter int IO_TIMEOUT  = 15
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    // Counter must be able to hold IO_TIMEOUT itself.
    localparam int CW = $clog2(IO_TIMEOUT + 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MEM_WR   = 3'd1;
    localparam logic [2:0] S_MEM_RD   = 3'd2;
    localparam logic [2:0] S_MEM_DATA = 3'd3;
    localparam logic [2:0] S_IO_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  size;
    } req_t;

    logic [2:0]    state, state_nxt;
    req_t          r;
    logic [31:0]   io_word;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          size_bad;
    logic          misaligned;
    logic          is_io;
    logic [7:0]    io_byte;
    logic [15:0]   io_half;
    logic [31:0]   io_ext;

    assign accept = (state == S_IDLE) && bus.req_valid;

    // Decode of the incoming request, evaluated on the request bus itself so
    // the first state after accept is already the right one.
    always_comb begin
        size_bad   = (bus.req_size == 3'b011) || (bus.req_size == 3'b110) ||
                     (bus.req_size == 3'b111);
        misaligned = ((bus.req_size[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        is_io      = bus.req_addr[IO_ADDR_BIT];
    end

    // Next-state logic; in IO_WAIT a ready seen on the expiry cycle still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (size_bad)
                        state_nxt = S_ERR;
                    else if (is_io && misaligned)
                        state_nxt = S_ERR;
                    else if (is_io)
                        state_nxt = S_IO_WAIT;
                    else if (bus.req_write)
                        state_nxt = S_MEM_WR;
                    else
                        state_nxt = S_MEM_RD;
                end
            end
            S_MEM_WR:   state_nxt = S_IDLE;
            S_MEM_RD:   state_nxt = S_MEM_DATA;
            S_MEM_DATA: state_nxt = S_IDLE;
            S_IO_WAIT: begin
                if (bus.io_ready)
                    state_nxt = S_RESP;
                else if (cnt == CW'(IO_TIMEOUT))
                    state_nxt = S_ERR;
            end
            S_RESP:     state_nxt = S_IDLE;
            S_ERR:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Request latch; every memory/IO output is driven from here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r <= '0;
        else if (accept)
            r <= '{addr: bus.req_addr, wdata: bus.req_wdata,
                   write: bus.req_write, size: bus.req_size};
    end

    // IO wait counter and captured IO read word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            io_word <= '0;
        end else begin
            if (accept)
                cnt <= '0;
            else if (state == S_IO_WAIT && !bus.io_ready && cnt != CW'(IO_TIMEOUT))
                cnt <= cnt + CW'(1);
            if (state == S_IO_WAIT && bus.io_ready)
                io_word <= bus.io_rdata;
        end
    end

    // Lane selection and extension of the captured IO word for loads.
    always_comb begin
        io_byte = 8'h00;
        case (r.addr[1:0])
            2'd0: io_byte = io_word[7:0];
            2'd1: io_byte = io_word[15:8];
            2'd2: io_byte = io_word[23:16];
            2'd3: io_byte = io_word[31:24];
            default: io_byte = 8'h00;
        endcase
        io_half = r.addr[1] ? io_word[31:16] : io_word[15:0];
        case (r.size)
            3'b000:  io_ext = {{24{io_byte[7]}}, io_byte};
            3'b100:  io_ext = {24'h0, io_byte};
            3'b001:  io_ext = {{16{io_half[15]}}, io_half};
            3'b101:  io_ext = {16'h0, io_half};
            3'b010:  io_ext = io_word;
            default: io_ext = 32'h0;
        endcase
    end

    // Output decode from state and latched request. MEM_DATA keeps the read
    // enable, address and size up so DataMemory's extension stays valid.
    always_comb begin
        bus.req_ready       = (state == S_IDLE);
        bus.mem_access_addr = r.addr;
        bus.mem_in          = r.wdata;
        bus.mem_data_size   = r.size;
        bus.mem_write_en    = (state == S_MEM_WR);
        bus.mem_read_en     = (state == S_MEM_RD) || (state == S_MEM_DATA);
        bus.io_addr         = r.addr;
        bus.io_wdata        = r.wdata;
        bus.io_size         = r.size;
        bus.io_we           = (state == S_IO_WAIT) && r.write;
        bus.io_re           = (state == S_IO_WAIT) && !r.write;
        bus.rsp_valid       = (state == S_MEM_WR) || (state == S_MEM_DATA) ||
                              (state == S_RESP) || (state == S_ERR);
        bus.rsp_error       = (state == S_ERR);
        bus.rsp_rdata       = 32'h0;
        if (state == S_MEM_DATA)
            bus.rsp_rdata = bus.mem_out;
        else if (state == S_RESP && !r.write)
            bus.rsp_rdata = io_ext;
    end
endmodule
